// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder/subtractor.
// The divisibility check is a macro so each top can assert its own parameter pair at elaboration.
`ifndef RCA_PKG_SV
`define RCA_PKG_SV

`define RCA_CHECK_DIVISIBLE(W, S) \
    if ((S) < 1 || (S) > (W) || ((W) % (S)) != 0) begin : g_bad_params \
        $error("rca: WIDTH must be a non-zero multiple of STAGES"); \
    end

package rca_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

`endif

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple chain of full adders; also exposes the carry into the top bit
// so the caller can form a signed-overflow flag.
module rca_chunk #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co,
    output logic         c_msb
);

    logic [N:0] w_c;

    always_comb begin
        w_c    = '0;
        sum    = '0;
        w_c[0] = ci;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i]     = x[i] ^ y[i] ^ w_c[i];
            w_c[i + 1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
        end
        co    = w_c[N];
        c_msb = w_c[N - 1];
    end

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, single global advance for valid/ready backpressure.
module rca_pipe_addsub
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

    `RCA_CHECK_DIVISIBLE(WIDTH, STAGES)

    // Operand bits at and below a stage's own chunk are never read again downstream.
    function automatic logic [WIDTH-1:0] hi_mask(input int unsigned k);
        return {WIDTH{1'b1}} << ((k + 1) * CHUNK);
    endfunction

    logic             r_v     [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_s     [STAGES];
    logic             r_c     [STAGES];
    logic             r_cmsb;

    logic             w_adv;
    logic             w_src_v [STAGES];
    logic [WIDTH-1:0] w_src_a [STAGES];
    logic [WIDTH-1:0] w_src_b [STAGES];
    logic [WIDTH-1:0] w_src_s [STAGES];
    logic             w_src_c [STAGES];
    logic [WIDTH-1:0] w_s_next[STAGES];

    logic [CHUNK-1:0] w_cx    [STAGES];
    logic [CHUNK-1:0] w_cy    [STAGES];
    logic [CHUNK-1:0] w_csum  [STAGES];
    logic             w_cci   [STAGES];
    logic             w_cco   [STAGES];
    logic             w_ccm   [STAGES];

    // Entry 0 of each w_src array is the conditioned input beat; entry k is stage k-1's registers.
    always_comb begin
        w_adv      = !r_v[STAGES-1] || out_ready;
        w_src_v[0] = in_valid && w_adv;
        w_src_a[0] = a;
        w_src_b[0] = (sub == OP_SUB) ? ~b : b;
        w_src_c[0] = (sub == OP_SUB) ? ~c : c;
        w_src_s[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_src_v[k] = r_v[k-1];
            w_src_a[k] = r_a[k-1];
            w_src_b[k] = r_b[k-1];
            w_src_s[k] = r_s[k-1];
            w_src_c[k] = r_c[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_cx[k]  = w_src_a[k][k*CHUNK +: CHUNK];
            w_cy[k]  = w_src_b[k][k*CHUNK +: CHUNK];
            w_cci[k] = w_src_c[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(.N(CHUNK)) u_chunk (
            .x     (w_cx[k]),
            .y     (w_cy[k]),
            .ci    (w_cci[k]),
            .sum   (w_csum[k]),
            .co    (w_cco[k]),
            .c_msb (w_ccm[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_s_next[k]                   = w_src_s[k];
            w_s_next[k][k*CHUNK +: CHUNK] = w_csum[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_cmsb <= 1'b0;
        end else if (w_adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k] <= w_src_v[k];
                r_a[k] <= w_src_a[k] & hi_mask(k);
                r_b[k] <= w_src_b[k] & hi_mask(k);
                r_s[k] <= w_s_next[k];
                r_c[k] <= w_cco[k];
            end
            r_cmsb <= w_ccm[STAGES-1];
        end
    end

    always_comb begin
        in_ready  = w_adv;
        out_valid = r_v[STAGES-1];
        s         = r_s[STAGES-1];
        co        = r_c[STAGES-1];
        ovf       = r_cmsb ^ r_c[STAGES-1];
    end

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Bench for rca_pipe_addsub: a 16/4 instance with directed and random traffic, plus 4/1 and 4/4
// instances swept exhaustively, all scored against an arithmetic model with random throttling.
module tb_rca_pipe_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit done [3];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned W = (g == 0) ? 16 : 4;
        localparam int unsigned S = (g == 1) ? 1 : 4;

        logic         rst = 1'b1;
        logic         in_valid = 1'b0;
        logic         out_ready = 1'b1;
        logic         in_ready, out_valid, co, ovf;
        logic         c = 1'b0;
        logic         sub = 1'b0;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic [W-1:0] s;

        logic [W+1:0] exp_q[$];
        logic [W-1:0] log_q[$];
        bit           log_en = 1'b0;
        bit           thr_en = 1'b0;

        rca_pipe_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .c         (c),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .s         (s),
            .co        (co),
            .ovf       (ovf)
        );

        // Reference result {ovf, co, s} from integer arithmetic on the raw operands.
        function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                               input logic mc, input logic msub);
            longint ua, ub, uc, sa, sb, r, sr;
            logic [63:0] rv;
            logic mco, movf;
            ua = longint'(ma);
            ub = longint'(mb);
            uc = longint'(mc);
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
            if (msub) begin
                r   = ua - ub - uc;
                mco = (ua >= ub + uc);
                sr  = sa - sb - uc;
            end else begin
                r   = ua + ub + uc;
                mco = (r >= (longint'(1) << W));
                sr  = sa + sb + uc;
            end
            movf = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));
            rv = r;
            return {movf, mco, rv[W-1:0]};
        endfunction

        always @(posedge clk) begin
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (log_en) log_q.push_back(s);
                end
                if (in_valid && in_ready) exp_q.push_back(model(a, b, c, sub));
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                check($sformatf("cfg%0d in_ready", g), in_ready, !out_valid || out_ready);
                if (out_valid) begin
                    if (exp_q.size() == 0)
                        check($sformatf("cfg%0d unexpected beat", g), out_valid, 1'b0);
                    else
                        check($sformatf("cfg%0d result", g), {ovf, co, s}, exp_q[0]);
                end
            end
        end

        initial forever begin
            @(posedge clk);
            #1;
            if (thr_en) out_ready = ($urandom_range(0, 3) != 0);
        end

        // Present one beat and hold it until accepted; returns just after the accepting edge.
        task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tc, input logic ts);
            bit got;
            got = 1'b0;
            a = ta; b = tb_v; c = tc; sub = ts; in_valid = 1'b1;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            check($sformatf("cfg%0d accept", g), got, 1'b1);
        endtask

        task automatic drain();
            thr_en = 1'b0;
            out_ready = 1'b1;
            for (int k = 0; k < 100 && (exp_q.size() != 0 || out_valid); k++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("cfg%0d drained", g), exp_q.size(), 0);
        endtask

        if (g == 0) begin : g_main
            task automatic op_lit(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                                  input logic tc, input logic ts, input logic [15:0] es,
                                  input logic eco, input logic eovf);
                int lat;
                out_ready = 1'b1;
                send(ta, tb_v, tc, ts);
                lat = 1;
                while (!out_valid && lat < 20) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check({nm, " latency"}, lat, 4);
                check({nm, " s"}, s, es);
                check({nm, " co"}, co, eco);
                check({nm, " ovf"}, ovf, eovf);
            endtask

            function automatic logic [15:0] pick();
                case ($urandom_range(0, 7))
                    0:       return 16'h0000;
                    1:       return 16'hFFFF;
                    2:       return 16'h7FFF;
                    3:       return 16'h8000;
                    4:       return 16'h0001;
                    default: return 16'($urandom);
                endcase
            endfunction

            initial begin
                rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111; out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("reset out_valid", out_valid, 1'b0);
                check("reset s", s, 16'h0000);
                check("reset co", co, 1'b0);
                check("reset ovf", ovf, 1'b0);
                @(posedge clk);
                #1;
                rst = 1'b0; in_valid = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    check("post-reset idle", out_valid, 1'b0);
                end
                @(posedge clk);
                #1;

                op_lit("add wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
                op_lit("signed ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
                op_lit("sub 5-7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
                op_lit("sub 0-1",     16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
                op_lit("sub min-1",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
                op_lit("add min+min", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
                op_lit("sub borrow",  16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

                @(posedge clk);
                #1;
                log_q.delete();
                log_en = 1'b1;
                fork
                    for (int i = 1; i <= 6; i++) send(16'(i), 16'(i), 1'b0, 1'b0);
                    begin
                        logic [16:0] held;
                        repeat (4) @(posedge clk);
                        #1;
                        out_ready = 1'b0;
                        @(negedge clk);
                        held = {out_valid, s};
                        check("stall out_valid", out_valid, 1'b1);
                        repeat (4) begin
                            @(negedge clk);
                            check("stall hold", {out_valid, s}, held);
                        end
                        @(posedge clk);
                        #1;
                        out_ready = 1'b1;
                    end
                join
                for (int k = 0; k < 50 && log_q.size() < 6; k++) @(posedge clk);
                #1;
                log_en = 1'b0;
                check("bp count", log_q.size(), 6);
                for (int i = 0; i < 6 && i < log_q.size(); i++)
                    check($sformatf("bp result %0d", i), log_q[i], 16'(2 * (i + 1)));

                drain();
                for (int i = 0; i < 3; i++) send(16'h0100 + 16'(i), 16'h0011, 1'b0, 1'b0);
                rst = 1'b1;
                @(posedge clk);
                #1;
                check("midrst out_valid", out_valid, 1'b0);
                check("midrst s", s, 16'h0000);
                rst = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    check("midrst no ghost", out_valid, 1'b0);
                end
                @(posedge clk);
                #1;
                op_lit("after midrst", 16'h0102, 16'h0304, 1'b1, 1'b0, 16'h0407, 1'b0, 1'b0);

                thr_en = 1'b1;
                repeat (400) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                drain();
                done[0] = 1'b1;
            end
        end else begin : g_sweep
            initial begin
                logic [8:0] vv;
                rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                thr_en = 1'b1;
                for (int m = 0; m < 2; m++) begin
                    for (int v = 0; v < 512; v++) begin
                        vv = 9'(v);
                        if ($urandom_range(0, 7) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send(vv[8:5], vv[4:1], vv[0], m[0]);
                    end
                end
                drain();
                done[g] = 1'b1;
            end
        end
    end

    initial begin
        for (int k = 0; k < 30000 && !(done[0] && done[1] && done[2]); k++) @(posedge clk);
        check("all configs finished", {29'b0, done[2], done[1], done[0]}, 32'd7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
